// File: rtl/masked_affine_pipe.sv
// masked_affine_pipe: applies one of four GF(2) linear/affine byte maps to
// every share of a Boolean-masked byte, then carries the result through
// STAGES handshaked register stages.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high. A producer must hold its payload stable while valid is high
// and ready is low. Ready never depends combinationally on valid.
//
// Shares never mix. Each output share is computed only from the same input
// share and the mode bits. The affine constant is added to share 0 only.
module masked_affine_pipe #(
    parameter int SHARES = 3,
    parameter int STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [8*SHARES-1:0]   in_shares,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_mode,
    output logic [8*SHARES-1:0]   out_shares
);

    localparam int W = 8 * SHARES;

    // Linear part of the selected map, applied to a single share byte.
    function automatic logic [7:0] map_lin(input logic [1:0] m, input logic [7:0] a);
        logic [7:0] z;
        z = 8'h00;
        case (m)
            2'd0: begin
                // Basis change into the inversion-friendly representation.
                z[7] = a[0] ^ a[1] ^ a[2] ^ a[5] ^ a[6] ^ a[7];
                z[6] = a[0] ^ a[4] ^ a[5] ^ a[6];
                z[5] = a[0] ^ a[1] ^ a[5] ^ a[6];
                z[4] = a[0] ^ a[5] ^ a[6] ^ a[7];
                z[3] = a[0] ^ a[1] ^ a[3] ^ a[4] ^ a[7];
                z[2] = a[0];
                z[1] = a[0] ^ a[5] ^ a[6];
                z[0] = a[0] ^ a[1] ^ a[2] ^ a[3] ^ a[6];
            end
            2'd1: begin
                // Forward affine matrix (indices wrap mod 8 via the 3-bit cast).
                for (int i = 0; i < 8; i++) begin
                    z[i] = a[i] ^ a[3'(i + 4)] ^ a[3'(i + 5)] ^ a[3'(i + 6)] ^ a[3'(i + 7)];
                end
            end
            2'd2: begin
                z = a;
            end
            default: begin
                // Inverse affine matrix.
                for (int i = 0; i < 8; i++) begin
                    z[i] = a[3'(i + 2)] ^ a[3'(i + 5)] ^ a[3'(i + 7)];
                end
            end
        endcase
        return z;
    endfunction

    // Affine constant of the selected map; added to share 0 only.
    function automatic logic [7:0] map_const(input logic [1:0] m);
        case (m)
            2'd1:    return 8'h63;
            2'd3:    return 8'h05;
            default: return 8'h00;
        endcase
    endfunction

    logic [W-1:0]     xf;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;
    logic [1:0]       mode_q [STAGES];
    logic [W-1:0]     data_q [STAGES];

    // Per-share transform in front of stage 1; no term crosses a share boundary.
    always_comb begin
        xf = '0;
        for (int s = 0; s < SHARES; s++) begin
            xf[8*s +: 8] = map_lin(in_mode, in_shares[8*s +: 8])
                         ^ ((s == 0) ? map_const(in_mode) : 8'h00);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         up_v;
        logic [1:0]   up_m;
        logic [W-1:0] up_d;
        logic         v_r;
        logic [1:0]   m_r;
        logic [W-1:0] d_r;

        if (k == 0) begin : g_first
            assign up_v = in_valid;
            assign up_m = in_mode;
            assign up_d = xf;
        end else begin : g_next
            assign up_v = v_q[k-1];
            assign up_m = mode_q[k-1];
            assign up_d = data_q[k-1];
        end

        // A stage can take new data when it is empty or some stage downstream
        // has room or the sink is draining; this flattens ~v(k) | r(k+1).
        assign rdy[k] = out_ready | ~(&v_q[STAGES-1:k]);

        // Stage register: valid follows upstream when ready; payload only
        // moves when a real transaction arrives, otherwise it holds.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                m_r <= 2'd0;
                d_r <= '0;
            end else if (rdy[k]) begin
                v_r <= up_v;
                if (up_v) begin
                    m_r <= up_m;
                    d_r <= up_d;
                end
            end
        end

        assign v_q[k]    = v_r;
        assign mode_q[k] = m_r;
        assign data_q[k] = d_r;
    end

    assign in_ready   = rdy[0];
    assign out_valid  = v_q[STAGES-1];
    assign out_mode   = mode_q[STAGES-1];
    assign out_shares = data_q[STAGES-1];

endmodule
